// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline write-back always wins, MDU results wait in a small FIFO.
// Define WB_ARB_STATS_EN to add saturating stall/kill statistics outputs.
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        pend_hazard,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0] stat_stall_cnt,
  output logic [15:0] stat_kill_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [4:0]       ent_rd_reg   [DEPTH];
  logic [31:0]      ent_data_reg [DEPTH];
  logic [DEPTH-1:0] ent_valid_reg;
  logic [DEPTH-1:0] ent_valid_next;
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [7:0]       starve_reg;
  logic [7:0]       starve_next;
  logic             stall_reg;

  logic             busy;
  logic             not_empty;
  logic             head_valid;
  logic             pop;
  logic             accept;
  logic             push;
  logic             ready_int;
  logic [DEPTH-1:0] kill_vec;
  logic [DEPTH-1:0] hit_vec;

  assign busy       = pipe_we && (pipe_rd != 5'd0);
  assign not_empty  = (count_reg != '0);
  assign head_valid = not_empty && ent_valid_reg[rd_ptr_reg];
  // A dead head leaves silently even when the pipeline owns the port.
  assign pop        = not_empty && (!head_valid || !busy);
  assign ready_int  = (count_reg < CW'(DEPTH));
  assign accept     = mdu_valid && ready_int;
  assign push       = accept && (mdu_rd != 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign kill_vec[gi] = busy && ent_valid_reg[gi] && (ent_rd_reg[gi] == pipe_rd);
      assign hit_vec[gi]  = ent_valid_reg[gi] &&
                            (((id_rs != 5'd0) && (ent_rd_reg[gi] == id_rs)) ||
                             ((id_rt != 5'd0) && (ent_rd_reg[gi] == id_rt)));
      // A fresh enqueue is younger than the pipeline write, so it survives a matching kill.
      assign ent_valid_next[gi] =
        (push && (wr_ptr_reg == PW'(gi))) ? 1'b1 :
        ((pop && (rd_ptr_reg == PW'(gi))) || kill_vec[gi]) ? 1'b0 :
        ent_valid_reg[gi];
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    starve_next = starve_reg;
    if (!not_empty || pop) begin
      starve_next = 8'd0;
    end else if (head_valid && busy && (starve_reg < LIMIT)) begin
      starve_next = starve_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_valid_reg <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      starve_reg    <= 8'd0;
      stall_reg     <= 1'b0;
    end else begin
      ent_valid_reg <= ent_valid_next;
      count_reg     <= count_next;
      starve_reg    <= starve_next;
      stall_reg     <= (starve_next == LIMIT);
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_reg[wr_ptr_reg]   <= mdu_rd;
      ent_data_reg[wr_ptr_reg] <= mdu_data;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (rst) begin
      if (busy) begin
        rf_we    = 1'b1;
        rf_waddr = pipe_rd;
        rf_wdata = pipe_data;
      end else if (head_valid) begin
        rf_we    = 1'b1;
        rf_waddr = ent_rd_reg[rd_ptr_reg];
        rf_wdata = ent_data_reg[rd_ptr_reg];
      end
    end
  end

  assign mdu_ready   = rst && ready_int;
  assign pend_hazard = rst && (|hit_vec);
  assign stall_req   = rst && stall_reg;

`ifdef WB_ARB_STATS_EN
  logic [15:0] stall_cnt_reg;
  logic [15:0] kill_cnt_reg;
  logic [CW-1:0] kill_num;
  logic [16:0]   kill_sum;

  always_comb begin
    kill_num = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_num = kill_num + CW'(kill_vec[i]);
    end
    kill_sum = {1'b0, kill_cnt_reg} + 17'(kill_num);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_reg <= 16'd0;
      kill_cnt_reg  <= 16'd0;
    end else begin
      if (stall_reg && (stall_cnt_reg != 16'hFFFF)) stall_cnt_reg <= stall_cnt_reg + 16'd1;
      kill_cnt_reg <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end
  end

  assign stat_stall_cnt = stall_cnt_reg;
  assign stat_kill_cnt  = kill_cnt_reg;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: queue-based reference model checked every cycle plus literal spot checks.
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        pend_hazard;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .id_rs(id_rs), .id_rt(id_rt), .pend_hazard(pend_hazard), .stall_req(stall_req),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          v;
  } ent_t;

  ent_t mq[$];
  int   starve = 0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_compare();
    logic        e_we, e_rdy, e_st, e_hz;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    bit          busy;
    busy = pipe_we && (pipe_rd != 5'd0);
    e_we = 0; e_a = 0; e_d = 0; e_rdy = 0; e_st = 0; e_hz = 0;
    if (rst) begin
      e_rdy = (mq.size() < DEPTH);
      e_st  = (starve == LIMIT);
      if (busy) begin
        e_we = 1; e_a = pipe_rd; e_d = pipe_data;
      end else if (mq.size() > 0 && mq[0].v) begin
        e_we = 1; e_a = mq[0].rd; e_d = mq[0].data;
      end
      foreach (mq[i])
        if (mq[i].v && ((id_rs != 0 && mq[i].rd == id_rs) || (id_rt != 0 && mq[i].rd == id_rt)))
          e_hz = 1;
    end
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(e_a));
    chk("rf_wdata", rf_wdata, e_d);
    chk("mdu_ready", 32'(mdu_ready), 32'(e_rdy));
    chk("stall_req", 32'(stall_req), 32'(e_st));
    chk("pend_hazard", 32'(pend_hazard), 32'(e_hz));
  endtask

  task automatic model_update();
    bit busy, pop, push;
    int sz;
    ent_t ne;
    busy = pipe_we && (pipe_rd != 5'd0);
    sz   = mq.size();
    if (!rst) begin
      mq.delete();
      starve = 0;
      $display("cycle %0d reset", cyc);
    end else begin
      pop  = (sz > 0) && (!mq[0].v || !busy);
      push = mdu_valid && (sz < DEPTH) && (mdu_rd != 5'd0);
      if (sz == 0 || pop) starve = 0;
      else if (mq[0].v && busy && starve < LIMIT) starve++;
      if (busy)
        $display("cycle %0d pipe write rd=%0d data=%h", cyc, pipe_rd, pipe_data);
      else if (sz > 0 && mq[0].v)
        $display("cycle %0d mdu write rd=%0d data=%h", cyc, mq[0].rd, mq[0].data);
      if (busy)
        foreach (mq[i]) if (mq[i].v && mq[i].rd == pipe_rd) mq[i].v = 0;
      if (pop) void'(mq.pop_front());
      if (push) begin
        ne.rd = mdu_rd; ne.data = mdu_data; ne.v = 1;
        mq.push_back(ne);
        $display("cycle %0d mdu enqueue rd=%0d data=%h", cyc, mdu_rd, mdu_data);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_compare();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic set_pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
    pipe_we = we; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mdu_valid = v; mdu_rd = rd; mdu_data = d;
  endtask

  initial begin
    rst = 1'b0; id_rs = 0; id_rt = 0;
    set_pipe(1, 5'd4, 32'h4444);
    set_mdu(1, 5'd2, 32'h2);
    #1;
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_ready", 32'(mdu_ready), 32'd0);
    tick(); tick();

    // single MDU result through an idle pipeline
    rst = 1'b1;
    set_pipe(0, 5'd0, 32'd0);
    set_mdu(1, 5'd5, 32'h1234_5678);
    #1;
    chk("s1_ready", 32'(mdu_ready), 32'd1);
    chk("s1_idle_we", 32'(rf_we), 32'd0);
    tick();
    set_mdu(0, 5'd0, 32'd0);
    #1;
    chk("s1_we", 32'(rf_we), 32'd1);
    chk("s1_waddr", 32'(rf_waddr), 32'd5);
    chk("s1_wdata", rf_wdata, 32'h1234_5678);
    tick();
    #1;
    chk("s1_drained_we", 32'(rf_we), 32'd0);
    chk("s1_model_empty", 32'(mq.size()), 32'd0);

    // starvation: busy pipeline holds the port
    set_pipe(1, 5'd3, 32'h0000_BEEF);
    set_mdu(1, 5'd7, 32'h77);
    tick();
    set_mdu(0, 5'd0, 32'd0);
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      chk("s2_no_stall", 32'(stall_req), 32'd0);
      chk("s2_waddr_pipe", 32'(rf_waddr), 32'd3);
      tick();
    end
    #1;
    chk("s2_stall", 32'(stall_req), 32'd1);
    set_pipe(0, 5'd0, 32'd0);
    #1;
    chk("s2_waddr_mdu", 32'(rf_waddr), 32'd7);
    chk("s2_wdata_mdu", rf_wdata, 32'h77);
    tick();
    #1;
    chk("s2_stall_fall", 32'(stall_req), 32'd0);
    chk("s2_idle_we", 32'(rf_we), 32'd0);

    // fill the buffer, then drain in order
    set_pipe(1, 5'd3, 32'h0000_0333);
    for (int i = 0; i < DEPTH; i++) begin
      set_mdu(1, 5'(10 + i), 32'(32'h100 + i));
      tick();
    end
    set_mdu(1, 5'd14, 32'h114);
    #1;
    chk("s3_full", 32'(mdu_ready), 32'd0);
    tick();
    set_pipe(0, 5'd0, 32'd0);
    #1;
    chk("s3_head0", 32'(rf_waddr), 32'd10);
    chk("s3_full_pop", 32'(mdu_ready), 32'd0);
    tick();
    #1;
    chk("s3_ready_after_pop", 32'(mdu_ready), 32'd1);
    chk("s3_head1", 32'(rf_waddr), 32'd11);
    tick();
    set_mdu(0, 5'd0, 32'd0);
    #1;
    chk("s3_head2", 32'(rf_waddr), 32'd12);
    tick();
    #1;
    chk("s3_head3", 32'(rf_waddr), 32'd13);
    tick();
    #1;
    chk("s3_head4", 32'(rf_waddr), 32'd14);
    chk("s3_data4", rf_wdata, 32'h114);
    tick();
    #1;
    chk("s3_empty_we", 32'(rf_we), 32'd0);

    // WAW kill of a queued rd=9
    set_pipe(1, 5'd2, 32'h22);
    set_mdu(1, 5'd9, 32'h99);
    tick();
    set_mdu(0, 5'd0, 32'd0);
    set_pipe(1, 5'd9, 32'h0000_AAAA);
    id_rs = 5'd9;
    #1;
    chk("s4_hazard_before", 32'(pend_hazard), 32'd1);
    chk("s4_waddr", 32'(rf_waddr), 32'd9);
    chk("s4_wdata", rf_wdata, 32'h0000_AAAA);
    tick();
    set_pipe(0, 5'd0, 32'd0);
    #1;
    chk("s4_hazard_killed", 32'(pend_hazard), 32'd0);
    chk("s4_silent_pop", 32'(rf_we), 32'd0);
    tick();
    id_rs = 5'd0;
    #1;
    chk("s4_we_after", 32'(rf_we), 32'd0);
    chk("s4_model_empty", 32'(mq.size()), 32'd0);

    // hazard detection and rd=0 handshake
    set_pipe(1, 5'd2, 32'h22);
    set_mdu(1, 5'd12, 32'hC);
    tick();
    set_mdu(0, 5'd0, 32'd0);
    id_rs = 5'd12;
    #1;
    chk("s5_hz_rs", 32'(pend_hazard), 32'd1);
    id_rs = 5'd0; id_rt = 5'd12;
    #1;
    chk("s5_hz_rt", 32'(pend_hazard), 32'd1);
    id_rt = 5'd0;
    #1;
    chk("s5_hz_zero", 32'(pend_hazard), 32'd0);
    set_mdu(1, 5'd0, 32'hDEAD);
    #1;
    chk("s5_rd0_ready", 32'(mdu_ready), 32'd1);
    tick();
    set_mdu(0, 5'd0, 32'd0);
    set_pipe(0, 5'd0, 32'd0);
    #1;
    chk("s5_waddr", 32'(rf_waddr), 32'd12);
    chk("s5_wdata", rf_wdata, 32'hC);
    tick();
    #1;
    chk("s5_rd0_not_queued", 32'(rf_we), 32'd0);

    // same-cycle enqueue matching the busy pipeline rd survives
    set_pipe(1, 5'd6, 32'h66);
    set_mdu(1, 5'd6, 32'h600D);
    #1;
    chk("s6_pipe_data", rf_wdata, 32'h66);
    tick();
    set_mdu(0, 5'd0, 32'd0);
    set_pipe(0, 5'd0, 32'd0);
    #1;
    chk("s6_waddr", 32'(rf_waddr), 32'd6);
    chk("s6_wdata", rf_wdata, 32'h600D);
    tick();

    // mid-operation reset discards the queue
    set_pipe(1, 5'd1, 32'h11);
    id_rs = 5'd21;
    for (int i = 0; i < 3; i++) begin
      set_mdu(1, 5'(20 + i), 32'(32'h200 + i));
      tick();
    end
    set_mdu(0, 5'd0, 32'd0);
    #1;
    chk("s7_hz_pre", 32'(pend_hazard), 32'd1);
    rst = 1'b0;
    #1;
    chk("s7_rst_we", 32'(rf_we), 32'd0);
    chk("s7_rst_waddr", 32'(rf_waddr), 32'd0);
    chk("s7_rst_wdata", rf_wdata, 32'd0);
    chk("s7_rst_ready", 32'(mdu_ready), 32'd0);
    chk("s7_rst_stall", 32'(stall_req), 32'd0);
    chk("s7_rst_hz", 32'(pend_hazard), 32'd0);
    tick();
    rst = 1'b1;
    set_pipe(0, 5'd0, 32'd0);
    #1;
    chk("s7_ready", 32'(mdu_ready), 32'd1);
    chk("s7_we", 32'(rf_we), 32'd0);
    chk("s7_hz", 32'(pend_hazard), 32'd0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
